// File: rtl/rvga_types.sv
// Shared types for the fetch stage: machine word, buffered fetch entry and fetch FSM states.
package rvga_types;

  typedef logic [31:0] rvga_word;

  typedef struct packed {
    rvga_word pc;
    rvga_word instr;
    logic     misal;
  } ifetch_entry_t;

  localparam rvga_word RVGA_NOP = 32'h0000_0013;
  localparam rvga_word PcStep   = 32'd4;

  typedef enum logic [1:0] {
    StFetch,
    StStall,
    StKill,
    StHalt
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Instruction buffer between fetch and decode. Flush wins over pop; a push in the flush cycle
// becomes the sole entry.
module ifetch_fifo
  import rvga_types::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  ifetch_entry_t entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output ifetch_entry_t head_o,
  output logic          valid_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  ifetch_entry_t   mem_q [Depth];
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] waddr;
  logic [CntW-1:0] count_q, count_d;
  logic            pop_eff;

  assign valid_o = (count_q != '0);
  assign pop_eff = pop_i && valid_o;
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    waddr   = wptr_q;
    if (flush_i) begin
      rptr_d  = '0;
      waddr   = '0;
      wptr_d  = push_i ? PtrW'(1) : '0;
      count_d = push_i ? CntW'(1) : '0;
    end else begin
      if (pop_eff) rptr_d = rptr_q + PtrW'(1);
      if (push_i)  wptr_d = wptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; valid_o gates every use of the head entry.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[waddr] <= entry_i;
  end

endmodule

// File: rtl/ifetch.sv
// Fetch stage: PC, single-outstanding icache request and decode buffer with redirect/kill.
// IFETCH_MISALIGN_CHK_EN turns misaligned redirects into a marker entry and a halt.
module ifetch
  import rvga_types::*;
#(
  parameter rvga_word    RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        decode_ready,
  output logic        ifetch_decode_valid,
  output logic [31:0] ifetch_decode_instr,
  output logic [31:0] ifetch_decode_pc,
  output logic        ifetch_decode_misal,
  output logic [31:0] ifetch_icache_addr,
  output logic        ifetch_icache_read,
  input  logic [31:0] icache_ifetch_rdata,
  input  logic        icache_ifetch_resp
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

  ifetch_state_t state_q, state_d;
  rvga_word      pc_q, pc_d;
  rvga_word      addr_q, addr_d;
  logic          read_q, read_d;

  logic            push, pop, flush;
  ifetch_entry_t   push_entry, head;
  logic            fifo_valid;
  logic [CntW-1:0] fifo_count;
  logic [CntW:0]   cnt_push, cnt_nopush;
  rvga_word        target;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign target = redirect_pc;
`else
  assign target = redirect_pc & ~32'h3;
`endif

  assign pop        = fifo_valid && decode_ready && !redirect_valid;
  assign cnt_push   = {1'b0, fifo_count} + {{CntW{1'b0}}, 1'b1} - {{CntW{1'b0}}, pop};
  assign cnt_nopush = {1'b0, fifo_count} - {{CntW{1'b0}}, pop};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    read_d     = read_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_entry = '{pc: pc_q, instr: icache_ifetch_rdata, misal: 1'b0};

    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = target;
      if (read_q && !icache_ifetch_resp) begin
        // Request in flight: keep addr/read stable and discard its data later.
        state_d = StKill;
`ifdef IFETCH_MISALIGN_CHK_EN
      end else if (redirect_pc[1:0] != 2'b00) begin
        push       = 1'b1;
        push_entry = '{pc: redirect_pc, instr: RVGA_NOP, misal: 1'b1};
        state_d    = StHalt;
        read_d     = 1'b0;
`endif
      end else begin
        state_d = StFetch;
        read_d  = 1'b1;
        addr_d  = target;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (read_q) begin
            if (icache_ifetch_resp) begin
              push = 1'b1;
              pc_d = pc_q + PcStep;
              if (cnt_push < DepthW) begin
                addr_d = pc_q + PcStep;
              end else begin
                read_d  = 1'b0;
                state_d = StStall;
              end
            end
          end else if (cnt_nopush < DepthW) begin
            read_d = 1'b1;
            addr_d = pc_q;
          end else begin
            state_d = StStall;
          end
        end
        StStall: begin
          if (pop) begin
            state_d = StFetch;
            read_d  = 1'b1;
            addr_d  = pc_q;
          end
        end
        StKill: begin
          if (icache_ifetch_resp) begin
            state_d = StFetch;
            read_d  = 1'b1;
            addr_d  = pc_q;
`ifdef IFETCH_MISALIGN_CHK_EN
            if (pc_q[1:0] != 2'b00) begin
              push       = 1'b1;
              push_entry = '{pc: pc_q, instr: RVGA_NOP, misal: 1'b1};
              state_d    = StHalt;
              read_d     = 1'b0;
              addr_d     = addr_q;
            end
`endif
          end
        end
        StHalt: begin
          state_d = StHalt;
        end
        default: begin
          state_d = StFetch;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
    end
  end

  ifetch_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .entry_i(push_entry),
    .pop_i  (pop),
    .flush_i(flush),
    .head_o (head),
    .valid_o(fifo_valid),
    .count_o(fifo_count)
  );

  assign ifetch_icache_addr  = addr_q;
  assign ifetch_icache_read  = read_q;
  assign ifetch_decode_valid = fifo_valid;
  assign ifetch_decode_instr = head.instr;
  assign ifetch_decode_pc    = head.pc;
  assign ifetch_decode_misal = fifo_valid & head.misal;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with a behavioural icache (per-address miss latency).
module tb_ifetch;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        decode_ready;
  logic        ifetch_decode_valid;
  logic [31:0] ifetch_decode_instr;
  logic [31:0] ifetch_decode_pc;
  logic        ifetch_decode_misal;
  logic [31:0] ifetch_icache_addr;
  logic        ifetch_icache_read;
  logic [31:0] icache_ifetch_rdata;
  logic        icache_ifetch_resp;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] miss_addr;
  int unsigned miss_lat;
  int unsigned wait_cnt;

  ifetch #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .decode_ready       (decode_ready),
    .ifetch_decode_valid(ifetch_decode_valid),
    .ifetch_decode_instr(ifetch_decode_instr),
    .ifetch_decode_pc   (ifetch_decode_pc),
    .ifetch_decode_misal(ifetch_decode_misal),
    .ifetch_icache_addr (ifetch_icache_addr),
    .ifetch_icache_read (ifetch_icache_read),
    .icache_ifetch_rdata(icache_ifetch_rdata),
    .icache_ifetch_resp (icache_ifetch_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Icache: hit in the request cycle, except miss_addr which answers after miss_lat cycles.
  always_ff @(posedge clk) begin
    if (rst || !ifetch_icache_read || icache_ifetch_resp) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign icache_ifetch_rdata = mem_word(ifetch_icache_addr);
  assign icache_ifetch_resp  = ifetch_icache_read &&
                               ((ifetch_icache_addr != miss_addr) || (wait_cnt >= miss_lat));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, 32'(ifetch_decode_valid), 32'd1);
    check({tag, ".pc"}, ifetch_decode_pc, pc);
    check({tag, ".instr"}, ifetch_decode_instr, mem_word(pc));
    check({tag, ".misal"}, 32'(ifetch_decode_misal), 32'd0);
  endtask

  task automatic chk_req(input string tag, input logic rd, input logic [31:0] addr);
    check({tag, ".read"}, 32'(ifetch_icache_read), 32'(rd));
    if (rd) check({tag, ".addr"}, ifetch_icache_addr, addr);
  endtask

  task automatic chk_empty(input string tag);
    check({tag, ".valid"}, 32'(ifetch_decode_valid), 32'd0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk_empty("rst");
    check("rst.read", 32'(ifetch_icache_read), 32'd0);
    check("rst.addr", ifetch_icache_addr, 32'h0);
    check("rst.misal", 32'(ifetch_decode_misal), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    decode_ready   = 1'b1;
    miss_addr      = 32'h0BAD_0000;
    miss_lat       = 0;

    // Reset, then hit streaming at one instruction per cycle.
    do_reset();
    step();
    chk_req("start", 1'b1, 32'h0);
    chk_empty("start");
    step();
    chk_head("s0", 32'h0);
    chk_req("s0", 1'b1, 32'h4);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_head($sformatf("s%0d", i), 32'(4 * i));
      chk_req($sformatf("s%0d", i), 1'b1, 32'(4 * i + 4));
    end

    // Decode stalled for five cycles: two entries buffered, request stops.
    decode_ready = 1'b0;
    do_reset();
    step();
    chk_req("bp.a", 1'b1, 32'h0);
    step();
    chk_head("bp.b", 32'h0);
    chk_req("bp.b", 1'b1, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head("bp.full", 32'h0);
      chk_req("bp.full", 1'b0, 32'h0);
    end
    decode_ready = 1'b1;
    step();
    chk_head("bp.f", 32'h4);
    chk_req("bp.f", 1'b1, 32'h8);
    step();
    chk_head("bp.g", 32'h8);
    chk_req("bp.g", 1'b1, 32'hC);

    // Ten-cycle miss on 0x40: request held stable, single entry afterwards.
    miss_addr = 32'h40;
    miss_lat  = 10;
    redirect(32'h40);
    chk_req("miss.0", 1'b1, 32'h40);
    chk_empty("miss.0");
    for (int i = 1; i <= 9; i++) begin
      step();
      chk_req("miss.hold", 1'b1, 32'h40);
      chk_empty("miss.hold");
    end
    step();
    chk_req("miss.resp", 1'b1, 32'h40);
    step();
    chk_head("miss.e0", 32'h40);
    chk_req("miss.e0", 1'b1, 32'h44);
    step();
    chk_head("miss.e1", 32'h44);

    // Redirect to 0x100 in the middle of a six-cycle miss on 0x20.
    miss_addr = 32'h20;
    miss_lat  = 6;
    redirect(32'h20);
    chk_req("kill.0", 1'b1, 32'h20);
    step();
    step();
    redirect(32'h100);
    for (int i = 0; i < 4; i++) begin
      chk_req("kill.hold", 1'b1, 32'h20);
      chk_empty("kill.hold");
      step();
    end
    chk_req("kill.new", 1'b1, 32'h100);
    chk_empty("kill.new");
    step();
    chk_head("kill.e0", 32'h100);
    chk_req("kill.e0", 1'b1, 32'h104);
    step();
    chk_head("kill.e1", 32'h104);

    // Redirect while the buffer pushes and pops in the same cycle.
    redirect(32'h200);
    chk_empty("rpp.flush");
    chk_req("rpp.flush", 1'b1, 32'h200);
    step();
    chk_head("rpp.e0", 32'h200);
    step();
    chk_head("rpp.e1", 32'h204);

    // Redirect with a full buffer and no outstanding request.
    decode_ready = 1'b0;
    step();
    chk_req("rfull.stall", 1'b0, 32'h0);
    chk_head("rfull.stall", 32'h204);
    decode_ready = 1'b1;
    redirect(32'h300);
    chk_empty("rfull.flush");
    chk_req("rfull.flush", 1'b1, 32'h300);
    step();
    chk_head("rfull.e0", 32'h300);

    // PC wraps modulo 2^32.
    redirect(32'hFFFF_FFFC);
    chk_req("wrap.0", 1'b1, 32'hFFFF_FFFC);
    step();
    chk_head("wrap.e0", 32'hFFFF_FFFC);
    chk_req("wrap.e0", 1'b1, 32'h0);
    step();
    chk_head("wrap.e1", 32'h0);

    // Reset in the middle of a miss abandons it.
    miss_addr = 32'h40;
    miss_lat  = 10;
    redirect(32'h40);
    step();
    step();
    do_reset();
    step();
    chk_req("rstmiss.0", 1'b1, 32'h0);
    step();
    chk_head("rstmiss.e0", 32'h0);

`ifdef IFETCH_MISALIGN_CHK_EN
    // Misaligned target yields one marker entry and halts until the next redirect.
    redirect(32'h102);
    check("mis.valid", 32'(ifetch_decode_valid), 32'd1);
    check("mis.pc", ifetch_decode_pc, 32'h102);
    check("mis.instr", ifetch_decode_instr, 32'h13);
    check("mis.misal", 32'(ifetch_decode_misal), 32'd1);
    check("mis.read", 32'(ifetch_icache_read), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_empty("mis.halt");
      check("mis.halt.read", 32'(ifetch_icache_read), 32'd0);
    end
    redirect(32'h300);
    chk_req("mis.resume", 1'b1, 32'h300);
    step();
    chk_head("mis.resume.e0", 32'h300);
`else
    // Low target bits are ignored.
    redirect(32'h102);
    chk_req("align.0", 1'b1, 32'h100);
    step();
    chk_head("align.e0", 32'h100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
